// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Elastic pipeline register: a chain of DEPTH payload stages with a
//   valid/ready handshake on both sides. Empty stages accept from behind even
//   while the downstream side is stalled, so gaps between payloads close up
//   (bubble compression). A synchronous flush squashes every stage. A
//   saturating counter records the cycles in which the output is stalled.
//
// Parameters
//   WIDTH   payload width in bits (>= 1)
//   DEPTH   number of register stages (>= 1)
//   BUBBLE  payload value held by every empty stage
//
// Ports
//   clk        clock; all state updates on the rising edge
//   reset      asynchronous active-low reset; clears all state immediately
//   in_valid   upstream presents a payload
//   in_ready   block accepts the payload this cycle (combinational)
//   in_data    upstream payload
//   flush      synchronous squash of all stages; blocks input this cycle
//   out_valid  last stage holds a payload (registered)
//   out_ready  downstream accepts this cycle
//   out_data   payload of the last stage, BUBBLE when empty (registered)
//   occupancy  number of valid stages (registered)
//   stall_cnt  saturating count of cycles with out_valid=1, out_ready=0

module pipe_stage_elastic #(
  parameter int unsigned       WIDTH  = 64,
  parameter int unsigned       DEPTH  = 1,
  parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [15:0]                  stall_cnt
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  // rdy[i]: stage i may load on the next edge.
  logic [DEPTH-1:0] rdy;
  logic             in_fire;
  logic             out_fire;

  // The ready chain rdy[i] = !v[i] | rdy[i+1] is unrolled through a running
  // accumulator so the vector never depends on itself inside this block.
  always_comb begin
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      acc        = acc | !v[i-1];
      rdy[i-1]   = acc;
    end
  end

  assign in_ready  = rdy[0] & !flush;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = v[DEPTH-1] & out_ready;

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  // Stage registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) d[i] <= BUBBLE;
    end else if (flush) begin
      v <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) d[i] <= BUBBLE;
    end else begin
      if (rdy[0]) begin
        v[0] <= in_valid;
        d[0] <= in_valid ? in_data : BUBBLE;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v[i] <= v[i-1];
          d[i] <= v[i-1] ? d[i-1] : BUBBLE;
        end
      end
    end
  end

  // Occupancy tracks popcount(v) incrementally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      unique case ({in_fire, out_fire})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Stall counter survives flush; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (v[DEPTH-1] && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;

  localparam int unsigned W     = 64;
  localparam int unsigned D     = 3;
  localparam logic [63:0] BUB   = 64'hDEAD;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pipe_stage_elastic #(.WIDTH(W), .DEPTH(D), .BUBBLE(BUB)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        iv;
    logic [63:0] din;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [63:0] e_od;
    int unsigned e_occ;
    int unsigned e_st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic [63:0] din,
                              input logic ordy, input logic fl,
                              input logic e_ir, input logic e_ov,
                              input logic [63:0] e_od,
                              input int unsigned e_occ, input int unsigned e_st);
    vec_t r;
    r.iv = iv; r.din = din; r.ordy = ordy; r.fl = fl;
    r.e_ir = e_ir; r.e_ov = e_ov; r.e_od = e_od;
    r.e_occ = e_occ; r.e_st = e_st;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  localparam logic [63:0] PA = 64'hAAAA_0000_0000_000A;
  localparam logic [63:0] PB = 64'hBBBB_0000_0000_000B;

  initial begin
    // Rows: inputs for one cycle and the outputs expected in that same cycle
    // (sampled before the edge that ends it).
    // Streaming, out_ready=1
    vecs.push_back(mk(1, 64'h11, 1, 0, 1, 0, BUB,   0, 0));
    vecs.push_back(mk(1, 64'h22, 1, 0, 1, 0, BUB,   1, 0));
    vecs.push_back(mk(1, 64'h33, 1, 0, 1, 0, BUB,   2, 0));
    vecs.push_back(mk(0, 64'h0,  1, 0, 1, 1, 64'h11, 3, 0));
    vecs.push_back(mk(0, 64'h0,  1, 0, 1, 1, 64'h22, 2, 0));
    vecs.push_back(mk(0, 64'h0,  1, 0, 1, 1, 64'h33, 1, 0));
    vecs.push_back(mk(0, 64'h0,  1, 0, 1, 0, BUB,   0, 0));
    // Back-pressure: five offered, three fit, then release
    vecs.push_back(mk(1, 64'h11, 0, 0, 1, 0, BUB,   0, 0));
    vecs.push_back(mk(1, 64'h22, 0, 0, 1, 0, BUB,   1, 0));
    vecs.push_back(mk(1, 64'h33, 0, 0, 1, 0, BUB,   2, 0));
    vecs.push_back(mk(1, 64'h44, 0, 0, 0, 1, 64'h11, 3, 0));
    vecs.push_back(mk(1, 64'h44, 0, 0, 0, 1, 64'h11, 3, 1));
    vecs.push_back(mk(1, 64'h44, 1, 0, 1, 1, 64'h11, 3, 2));
    vecs.push_back(mk(1, 64'h55, 1, 0, 1, 1, 64'h22, 3, 2));
    vecs.push_back(mk(0, 64'h0,  1, 0, 1, 1, 64'h33, 3, 2));
    vecs.push_back(mk(0, 64'h0,  1, 0, 1, 1, 64'h44, 2, 2));
    vecs.push_back(mk(0, 64'h0,  1, 0, 1, 1, 64'h55, 1, 2));
    vecs.push_back(mk(0, 64'h0,  1, 0, 1, 0, BUB,   0, 2));
    // Bubble compression: A, gap, B under stall
    vecs.push_back(mk(1, PA,     0, 0, 1, 0, BUB,   0, 2));
    vecs.push_back(mk(0, 64'h0,  0, 0, 1, 0, BUB,   1, 2));
    vecs.push_back(mk(1, PB,     0, 0, 1, 0, BUB,   1, 2));
    vecs.push_back(mk(0, 64'h0,  0, 0, 1, 1, PA,    2, 2));
    vecs.push_back(mk(0, 64'h0,  0, 0, 1, 1, PA,    2, 3));
    vecs.push_back(mk(0, 64'h0,  1, 0, 1, 1, PA,    2, 4));
    vecs.push_back(mk(0, 64'h0,  1, 0, 1, 1, PB,    1, 4));
    vecs.push_back(mk(0, 64'h0,  1, 0, 1, 0, BUB,   0, 4));
    // Flush with two in flight and a third offered
    vecs.push_back(mk(1, 64'hC1, 0, 0, 1, 0, BUB,   0, 4));
    vecs.push_back(mk(1, 64'hC2, 0, 0, 1, 0, BUB,   1, 4));
    vecs.push_back(mk(1, 64'hC3, 0, 1, 0, 0, BUB,   2, 4));
    vecs.push_back(mk(0, 64'h0,  1, 0, 1, 0, BUB,   0, 4));
    vecs.push_back(mk(0, 64'h0,  1, 0, 1, 0, BUB,   0, 4));

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Asynchronous reset before any clock edge
    #1 reset = 1'b0;
    #1;
    chk("rst_out_valid", 0, 64'(out_valid), 64'd0);
    chk("rst_out_data",  0, out_data,       BUB);
    chk("rst_occupancy", 0, 64'(occupancy), 64'd0);
    chk("rst_stall_cnt", 0, 64'(stall_cnt), 64'd0);
    chk("rst_in_ready",  0, 64'(in_ready),  64'd1);

    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].din;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      #1;
      chk("in_ready",  i, 64'(in_ready),  64'(vecs[i].e_ir));
      chk("out_valid", i, 64'(out_valid), 64'(vecs[i].e_ov));
      chk("out_data",  i, out_data,       vecs[i].e_od);
      chk("occupancy", i, 64'(occupancy), 64'(vecs[i].e_occ));
      chk("stall_cnt", i, 64'(stall_cnt), 64'(vecs[i].e_st));
      @(posedge clk); #1;
    end

    // Saturation: park one payload at the output and stall well past 0xFFFF
    in_valid  = 1'b1;
    in_data   = 64'h5A;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (65600) @(posedge clk);
    #1;
    chk("sat_stall_cnt", 0, 64'(stall_cnt), 64'hFFFF);
    chk("sat_out_valid", 0, 64'(out_valid), 64'd1);
    chk("sat_out_data",  0, out_data,       64'h5A);
    chk("sat_occupancy", 0, 64'(occupancy), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", 0, 64'(stall_cnt), 64'hFFFF);

    // Mid-cycle asynchronous reset, checked before the next edge
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_stall_cnt", 0, 64'(stall_cnt), 64'd0);
    chk("mid_rst_out_valid", 0, 64'(out_valid), 64'd0);
    chk("mid_rst_out_data",  0, out_data,       BUB);
    chk("mid_rst_occupancy", 0, 64'(occupancy), 64'd0);
    chk("mid_rst_in_ready",  0, 64'(in_ready),  64'd1);

    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_out_valid", 0, 64'(out_valid), 64'd0);
    chk("post_rst_stall_cnt", 0, 64'(stall_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline register: a chain of DEPTH payload stages with a valid/ready handshake on both sides, bubble compression, synchronous flush and a saturating stall counter. It generalises the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) so a pipeline boundary can carry any bundled payload width. It adds back-pressure and squash support for hazard and branch-mispredict handling.

## Interface
Parameters:
- WIDTH, 64, payload width in bits (≥1)
- DEPTH, 1, number of register stages (≥1)
- BUBBLE, '0, WIDTH-bit payload value held by every empty stage

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- in_valid  in  1  upstream presents a payload
- in_ready  out  1  block accepts the payload this cycle
- in_data  in  WIDTH  upstream payload
- flush  in  1  synchronous squash of all stages
- out_valid  out  1  stage DEPTH-1 holds a payload
- out_ready  in  1  downstream accepts this cycle
- out_data  out  WIDTH  payload of stage DEPTH-1
- occupancy  out  $clog2(DEPTH+1)  count of valid stages
- stall_cnt  out  16  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Stage i holds v[i] and d[i]. Stage 0 is the input side; stage DEPTH-1 drives out_valid and out_data.
- Ready chain: rdy[DEPTH]=out_ready; rdy[i] = !v[i] | rdy[i+1]. in_ready = rdy[0] & !flush.
- Fires: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Stage advance on an edge when rdy[i]=1:
  - Stage 0 loads v=in_valid & !flush.
  - Stage i>0 loads v[i-1].
  - d loads the incoming payload when the incoming valid is 1, else BUBBLE.
  - When rdy[i]=0 the stage holds.
- Empty stages always contain BUBBLE, so out_data=BUBBLE whenever out_valid=0.
- Bubble compression: an empty stage accepts from behind even while downstream is stalled. DEPTH payloads can accumulate under out_ready=0.
- Ordering: payloads leave in acceptance order, with no loss or duplication.
- flush=1 (highest priority below reset):
  - At the edge, all v become 0 and all d become BUBBLE.
  - occupancy becomes 0.
  - in_ready=0 in the flush cycle, so no input is accepted.
  - out_valid/out_data are still driven from registers that cycle. A coincident out_fire counts as a completed transfer.
- occupancy register: next = occupancy + in_fire − out_fire. Flush forces 0. It must always equal popcount(v).
- stall_cnt: increments when out_valid & !out_ready. Saturates at 0xFFFF. Flush does not clear it; only reset does.
- reset=0 (asynchronous):
  - v=0, d=BUBBLE, occupancy=0, stall_cnt=0.
  - Outputs therefore read out_valid=0, out_data=BUBBLE, in_ready=out_ready-independent 1 (all stages empty).
  - Deassertion takes effect at the next posedge.

## Timing
- Latency: a payload accepted at edge N appears on out_valid after edge N+DEPTH−1, i.e. visible in cycle N+DEPTH relative to the accept cycle. The block must be empty ahead of it with no stall.
- Throughput: one payload per cycle sustained when out_ready=1.
- in_ready is combinational from out_ready and v[]. The path is DEPTH stages deep.
- out_valid, out_data, occupancy and stall_cnt are pure register outputs.
- Simultaneous cases:
  - in_fire and out_fire in the same cycle with the block full: allowed, because rdy propagates. Occupancy is unchanged.
  - flush with in_valid=1: input is dropped; upstream sees in_ready=0.
  - flush with reset=0: reset wins.
- Reset mid-stream: all in-flight payloads are discarded immediately, without waiting for a clock.

## Test plan
- Reset: with WIDTH=64, DEPTH=3, BUBBLE=0xDEAD, assert reset=0 → out_valid=0, out_data=0xDEAD, occupancy=0, stall_cnt=0, in_ready=1. No clock edge is required.
- Streaming: DEPTH=3, out_ready=1, inject 0x11, 0x22, 0x33 on consecutive cycles → outputs 0x11, 0x22, 0x33 on three consecutive cycles, first one 3 cycles after accept. occupancy peaks at 3 and in_ready stays 1.
- Back-pressure: out_ready=0, offer 5 payloads → exactly 3 accepted, then in_ready=0, occupancy=3. stall_cnt rises by 1 per stalled cycle. Raising out_ready → 0x11…0x33 in order, then the remaining two, with no duplicates.
- Bubble compression: DEPTH=3, send A, gap, B with out_ready=0 → after 4 cycles occupancy=2 and B sits directly behind A. Release → A then B on consecutive cycles.
- Flush: occupancy=2 and in_valid=1 on the flush cycle → in_ready=0 that cycle. Next cycle out_valid=0, out_data=BUBBLE, occupancy=0. The offered input never appears; stall_cnt is retained.
- Saturation/async reset: hold out_valid=1, out_ready=0 for 70000 cycles → stall_cnt=0xFFFF and holds. Then pulse reset=0 mid-cycle → stall_cnt=0 and out_valid=0 before the next edge.
